lsu_mem_bridge: RTL and testbench

//  Load/store bridge between the multi-stage core's memory stage and the data-memory

---
 rtl/lsu_mem_bridge_if.sv | 33 +++
 rtl/lsu_mem_bridge.sv | 175 +++++++++++++++++
 tb/tb_lsu_mem_bridge.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_bridge_if.sv
// Core-request/response and data-memory handshake bundle for lsu_mem_bridge.
// slave is the bridge's view; master is the core-plus-memory side.
interface lsu_mem_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_err,
           mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_err,
           mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_bridge.sv
// Load/store bridge: one core request in flight, alignment/funct3 checks,
// req/ack memory handshake with timeout, formatted single-cycle response.
module lsu_mem_bridge #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  lsu_mem_bridge_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lane_q, lane_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_mis_q, rsp_mis_d;
  logic              rsp_err_q, rsp_err_d;

  logic              size_bad, illegal, misaligned;
  logic [3:0]        st_strb;
  logic [31:0]       st_wdata;
  logic [31:0]       ld_shift;
  logic [31:0]       ld_data;

  // Request decode on the incoming core fields (used only at accept).
  always_comb begin
    size_bad   = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
    illegal    = size_bad || (bus.req_we && bus.req_funct3[2]);
    misaligned = !size_bad &&
                 (((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                  ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00)));
    st_strb  = 4'b1111;
    st_wdata = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'b00: begin
        st_strb  = 4'(4'b0001 << bus.req_addr[1:0]);
        st_wdata = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        st_strb  = 4'(4'b0011 << bus.req_addr[1:0]);
        st_wdata = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select and sign/zero extension of the returned word.
  always_comb begin
    ld_shift = bus.mem_rdata >> {lane_q, 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {24'h0, ld_shift[7:0]};
      3'b101:  ld_data = {16'h0, ld_shift[15:0]};
      default: ld_data = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_mis_d   = 1'b0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          we_d   = bus.req_we;
          f3_d   = bus.req_funct3;
          lane_d = bus.req_addr[1:0];
          cnt_d  = '0;
          if (illegal || misaligned) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = illegal;
            rsp_mis_d   = misaligned;
          end else begin
            state_d     = ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.req_we;
            mem_addr_d  = {bus.req_addr[31:2], 2'b00};
            mem_wstrb_d = bus.req_we ? st_strb : 4'b0000;
            mem_wdata_d = bus.req_we ? st_wdata : 32'h0;
          end
        end
      end
      ACCESS: begin
        // An ack in the timeout cycle still completes normally.
        if (bus.mem_ack || (cnt_q == TO_W'(TIMEOUT - 1))) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !bus.mem_ack;
          rsp_rdata_d = (bus.mem_ack && !we_q) ? ld_data : 32'h0;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'h0;
          mem_wstrb_d = 4'b0000;
          mem_wdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      lane_q      <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_mis_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_mis_q   <= rsp_mis_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready      = (state_q == IDLE) && rst;
  assign bus.mem_req        = mem_req_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wstrb      = mem_wstrb_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_misaligned = rsp_mis_q;
  assign bus.rsp_err        = rsp_err_q;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed bench for lsu_mem_bridge (TIMEOUT=4); inputs driven and outputs
// sampled on the falling clock edge.
module tb_lsu_mem_bridge;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  lsu_mem_bridge_if bus();

  lsu_mem_bridge #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input string tag);
    @(negedge clk);
    check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_wdata  = 32'h0;
  endtask

  // Normal transaction acked in the first ACCESS cycle.
  task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] word,
                      input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                      input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                      input string tag);
    issue(we, f3, addr, wdata, tag);
    check({tag, " mem_req"},   32'(bus.mem_req), 32'd1);
    check({tag, " mem_we"},    32'(bus.mem_we), 32'(we));
    check({tag, " mem_addr"},  bus.mem_addr, exp_addr);
    check({tag, " mem_wstrb"}, 32'(bus.mem_wstrb), 32'(exp_strb));
    if (we) check({tag, " mem_wdata"}, bus.mem_wdata, exp_wdata);
    check({tag, " early rsp"}, 32'(bus.rsp_valid), 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = word;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'hBAD0_BAD0;
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, " rdata"},     bus.rsp_rdata, exp_rdata);
    check({tag, " flags"},     {30'h0, bus.rsp_err, bus.rsp_misaligned}, 32'h0);
    check({tag, " req drop"},  32'(bus.mem_req), 32'd0);
    @(negedge clk);
    check({tag, " rsp pulse"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, " idle"},      32'(bus.req_ready), 32'd1);
  endtask

  // Request rejected at accept: response next cycle, no memory access.
  task automatic reject(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic exp_err, input logic exp_mis, input string tag);
    issue(we, f3, addr, 32'h5555_5555, tag);
    check({tag, " no mem_req"}, 32'(bus.mem_req), 32'd0);
    check({tag, " rsp_valid"},  32'(bus.rsp_valid), 32'd1);
    check({tag, " flags"},      {30'h0, bus.rsp_err, bus.rsp_misaligned},
                                {30'h0, exp_err, exp_mis});
    check({tag, " rdata"},      bus.rsp_rdata, 32'h0);
    @(negedge clk);
    check({tag, " rsp pulse"},  32'(bus.rsp_valid), 32'd0);
    check({tag, " ready"},      32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'h0;
    #1;
    check("rst ready",   32'(bus.req_ready), 32'd0);
    check("rst mem_req", 32'(bus.mem_req), 32'd0);
    check("rst rsp",     32'(bus.rsp_valid), 32'd0);
    check("rst wstrb",   32'(bus.mem_wstrb), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("post-rst ready", 32'(bus.req_ready), 32'd1);

    // Stray ack while idle must be ignored.
    @(negedge clk);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("idle ack rsp",   32'(bus.rsp_valid), 32'd0);
    check("idle ack ready", 32'(bus.req_ready), 32'd1);

    xfer(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 32'h0000_0100, 4'b0000,
         32'h0, 32'hDEAD_BEEF, "LW");
    xfer(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 32'h0000_0100, 4'b0000,
         32'h0, 32'hFFFF_FF80, "LB");
    xfer(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_0000, 32'h0000_0100, 4'b0000,
         32'h0, 32'h0000_0080, "LBU");
    xfer(1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h80FF_0000, 32'h0000_0100, 4'b0000,
         32'h0, 32'hFFFF_80FF, "LH");
    xfer(1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h80FF_0000, 32'h0000_0100, 4'b0000,
         32'h0, 32'h0000_80FF, "LHU");
    xfer(1'b0, 3'b000, 32'h0000_0201, 32'h0, 32'h0000_7F00, 32'h0000_0200, 4'b0000,
         32'h0, 32'h0000_007F, "LB pos");
    xfer(1'b1, 3'b000, 32'h0000_0022, 32'h1234_56AB, 32'h0, 32'h0000_0020, 4'b0100,
         32'hABAB_ABAB, 32'h0, "SB");
    xfer(1'b1, 3'b001, 32'h0000_0022, 32'h1234_56AB, 32'h0, 32'h0000_0020, 4'b1100,
         32'h56AB_56AB, 32'h0, "SH");
    xfer(1'b1, 3'b010, 32'h0000_0024, 32'hCAFE_F00D, 32'h0, 32'h0000_0024, 4'b1111,
         32'hCAFE_F00D, 32'h0, "SW");

    reject(1'b0, 3'b010, 32'h0000_0102, 1'b0, 1'b1, "LW mis");
    reject(1'b0, 3'b001, 32'h0000_0101, 1'b0, 1'b1, "LH mis");
    reject(1'b0, 3'b011, 32'h0000_0100, 1'b1, 1'b0, "f3 011");
    reject(1'b1, 3'b100, 32'h0000_0100, 1'b1, 1'b0, "store f3 100");

    // Never acked: mem_req holds for exactly TIMEOUT cycles, then error response.
    issue(1'b0, 3'b010, 32'h0000_0300, 32'h0, "TO");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("TO mem_req c%0d", i), 32'(bus.mem_req), 32'd1);
      check($sformatf("TO rsp c%0d", i),     32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
    end
    check("TO drop",  32'(bus.mem_req), 32'd0);
    check("TO rsp",   32'(bus.rsp_valid), 32'd1);
    check("TO err",   32'(bus.rsp_err), 32'd1);
    check("TO rdata", bus.rsp_rdata, 32'h0);
    @(negedge clk);
    check("TO pulse", 32'(bus.rsp_valid), 32'd0);

    // Ack in the final allowed cycle completes normally.
    issue(1'b0, 3'b010, 32'h0000_0300, 32'h0, "TO4");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("TO4 mem_req c%0d", i), 32'(bus.mem_req), 32'd1);
      @(negedge clk);
    end
    check("TO4 mem_req c3", 32'(bus.mem_req), 32'd1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    check("TO4 rsp",   32'(bus.rsp_valid), 32'd1);
    check("TO4 err",   32'(bus.rsp_err), 32'd0);
    check("TO4 rdata", bus.rsp_rdata, 32'h1234_5678);
    @(negedge clk);

    // Reset mid-ACCESS: mem_req drops at once and no response follows.
    issue(1'b0, 3'b010, 32'h0000_0400, 32'h0, "RST");
    check("RST mem_req", 32'(bus.mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("RST drop",  32'(bus.mem_req), 32'd0);
    check("RST ready", 32'(bus.req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("RST no rsp c%0d", i), 32'(bus.rsp_valid), 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("RST idle rsp c%0d", i), 32'(bus.rsp_valid), 32'd0);
      check($sformatf("RST idle req c%0d", i), 32'(bus.mem_req), 32'd0);
    end
    xfer(1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'h0BAD_F00D, 32'h0000_0104, 4'b0000,
         32'h0, 32'h0BAD_F00D, "LW after rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
